// File: rtl/seq_counter_ctrl.sv
// Run controller for the 5-state sequence counter (000->010->111->101->110).
// Clears the counter, gates its enable, and stops on a step count or a target code.
module seq_counter_ctrl #(
  parameter int STEP_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_mode,
  input  logic [STEP_W-1:0] i_n_steps,
  input  logic [2:0]        i_target,
  input  logic              i_q_a,
  input  logic              i_q_b,
  input  logic              i_q_c,
  output logic              o_cnt_clr,
  output logic              o_cnt_en,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [STEP_W-1:0] o_steps_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Codes outside the 5-state cycle: never reachable from 000.
  function automatic logic is_illegal(input logic [2:0] code);
    is_illegal = (code == 3'b001) || (code == 3'b011) || (code == 3'b100);
  endfunction

  state_t              r_state;
  state_t              w_next_state;
  logic                r_mode;
  logic [2:0]          r_target;
  logic [STEP_W-1:0]   r_remaining;
  logic [STEP_W-1:0]   r_steps_done;
  logic [2:0]          w_q;
  logic                w_launch;
  logic                w_en;
  logic                w_step_inc;

  assign w_q        = {i_q_a, i_q_b, i_q_c};
  assign w_step_inc = (r_mode == 1'b0) || (r_steps_done < STEP_W'(3'd4));

  // Next-state and counter-enable decode; abort outranks every state rule.
  always_comb begin
    w_next_state = r_state;
    w_launch     = 1'b0;
    w_en         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_launch = 1'b1;
          if (i_mode && is_illegal(i_target)) begin
            w_next_state = S_ERR;
          end else begin
            w_next_state = S_CLEAR;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else if (is_illegal(w_q)) begin
          w_next_state = S_ERR;
        end else if (r_mode) begin
          if (w_q == r_target) begin
            w_next_state = S_DONE;
          end else begin
            w_en = 1'b1;
          end
        end else begin
          if (r_remaining == {STEP_W{1'b0}}) begin
            w_next_state = S_DONE;
          end else begin
            w_en = 1'b1;
          end
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      S_ERR: begin
        if (i_abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_ERR;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Run parameters latched at launch; step bookkeeping follows the enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mode       <= 1'b0;
      r_target     <= 3'b000;
      r_remaining  <= {STEP_W{1'b0}};
      r_steps_done <= {STEP_W{1'b0}};
    end else if (w_launch) begin
      r_mode       <= i_mode;
      r_target     <= i_target;
      r_remaining  <= i_n_steps;
      r_steps_done <= {STEP_W{1'b0}};
    end else if (w_en) begin
      if (!r_mode) begin
        r_remaining <= r_remaining - STEP_W'(1'b1);
      end
      if (w_step_inc) begin
        r_steps_done <= r_steps_done + STEP_W'(1'b1);
      end
    end
  end

  assign o_cnt_clr    = (r_state == S_CLEAR);
  assign o_busy       = (r_state == S_CLEAR) || (r_state == S_RUN);
  assign o_done       = (r_state == S_DONE);
  assign o_err        = (r_state == S_ERR);
  assign o_cnt_en     = w_en;
  assign o_steps_done = r_steps_done;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Bench for seq_counter_ctrl: drives a behavioural sequence counter from the
// controller outputs and checks per-cycle flags against run outcomes.
module tb_seq_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, mode;
  logic [3:0] n_steps;
  logic [2:0] target;
  logic       cnt_clr, cnt_en, busy, done, err;
  logic [3:0] steps_done;

  logic [2:0] q_code = 3'b000;
  bit         force_en = 1'b0;
  logic [2:0] force_val = 3'b000;

  int n_checks = 0;
  int n_fail = 0;

  logic [2:0] seq_codes [5] = '{3'b000, 3'b010, 3'b111, 3'b101, 3'b110};

  typedef struct {
    bit         mode;
    logic [3:0] n;
    logic [2:0] tgt;
    bit         e_err;
    int         k;
    logic [2:0] code;
  } vec_t;

  vec_t tbl [6];

  seq_counter_ctrl #(.STEP_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_mode(mode), .i_n_steps(n_steps), .i_target(target),
    .i_q_a(q_code[2]), .i_q_b(q_code[1]), .i_q_c(q_code[0]),
    .o_cnt_clr(cnt_clr), .o_cnt_en(cnt_en), .o_busy(busy),
    .o_done(done), .o_err(err), .o_steps_done(steps_done)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] next_code(input logic [2:0] c);
    case (c)
      3'b000:  next_code = 3'b010;
      3'b010:  next_code = 3'b111;
      3'b111:  next_code = 3'b101;
      3'b101:  next_code = 3'b110;
      3'b110:  next_code = 3'b000;
      default: next_code = 3'b000;
    endcase
  endfunction

  // External counter model, with a hook to inject an arbitrary code.
  always @(posedge clk) begin
    if (force_en) q_code <= force_val;
    else if (cnt_clr) q_code <= 3'b000;
    else if (cnt_en) q_code <= next_code(q_code);
  end

  function automatic logic [4:0] flags();
    return {cnt_clr, cnt_en, busy, done, err};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outcome of a run from the sequence order alone.
  task automatic ref_model(input bit m, input logic [3:0] n, input logic [2:0] tgt,
                           output bit e_err, output int k, output logic [2:0] code);
    e_err = 1'b0; k = 0; code = 3'b000;
    if (!m) begin
      k = int'(n);
      code = seq_codes[k % 5];
    end else begin
      e_err = 1'b1;
      for (int i = 0; i < 5; i++) begin
        if (seq_codes[i] == tgt) begin
          e_err = 1'b0; k = i; code = tgt;
        end
      end
    end
  endtask

  task automatic run_check(input bit m, input logic [3:0] n, input logic [2:0] tgt,
                           input bit e_err, input int k, input logic [2:0] code,
                           input string tag);
    int d;
    logic [4:0] e;
    @(negedge clk);
    mode = m; n_steps = n; target = tgt; start = 1'b1;
    #1 chk($sformatf("%s c0 flags", tag), 32'(flags()), 32'(5'b00000));
    if (e_err) begin
      @(negedge clk); start = 1'b0;
      #1 chk($sformatf("%s err c1", tag), 32'(flags()), 32'(5'b00001));
      abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      #1 chk($sformatf("%s abort idle", tag), 32'(flags()), 32'(5'b00000));
    end else begin
      d = k + 3;
      for (int c = 1; c <= d + 1; c++) begin
        @(negedge clk); start = 1'b0;
        e = {c == 1, (c >= 2) && (c <= k + 1), (c >= 1) && (c <= k + 2), c == d, 1'b0};
        #1 chk($sformatf("%s c%0d flags", tag, c), 32'(flags()), 32'(e));
        if (c == d) begin
          chk($sformatf("%s steps", tag), 32'(steps_done), 32'(k));
          chk($sformatf("%s code", tag), 32'(q_code), 32'(code));
        end
      end
    end
  endtask

  initial begin
    bit   r_err;
    int   r_k;
    logic [2:0] r_code;
    int   pulses;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; n_steps = 4'd0; target = 3'd0;
    tbl[0] = '{1'b0, 4'd3, 3'b000, 1'b0, 3, 3'b101};
    tbl[1] = '{1'b0, 4'd0, 3'b000, 1'b0, 0, 3'b000};
    tbl[2] = '{1'b0, 4'd7, 3'b000, 1'b0, 7, 3'b111};
    tbl[3] = '{1'b1, 4'd0, 3'b110, 1'b0, 4, 3'b110};
    tbl[4] = '{1'b1, 4'd9, 3'b000, 1'b0, 0, 3'b000};
    tbl[5] = '{1'b1, 4'd2, 3'b011, 1'b1, 0, 3'b000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset flags", 32'(flags()), 32'(5'b00000));
    chk("reset steps", 32'(steps_done), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run_check(tbl[i].mode, tbl[i].n, tbl[i].tgt, tbl[i].e_err, tbl[i].k, tbl[i].code,
                $sformatf("tbl%0d", i));

    // Reset in the middle of a run.
    @(negedge clk); mode = 1'b0; n_steps = 4'd7; start = 1'b1;
    for (int c = 1; c <= 4; c++) begin @(negedge clk); start = 1'b0; end
    #1 chk("rstmid steps c4", 32'(steps_done), 32'd2);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1 chk("rstmid flags", 32'(flags()), 32'(5'b00000));
    chk("rstmid steps", 32'(steps_done), 32'd0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin @(negedge clk); #1 if (done) pulses++; end
    chk("rstmid no done", 32'(pulses), 32'd0);

    // Illegal code injected mid-run, then start ignored in ERR.
    @(negedge clk); mode = 1'b0; n_steps = 4'd5; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin @(negedge clk); start = 1'b0; end
    force_en = 1'b1; force_val = 3'b100;
    @(negedge clk); force_en = 1'b0;
    #1 chk("illegal c4 flags", 32'(flags()), 32'(5'b00100));
    @(negedge clk);
    #1 chk("illegal c5 flags", 32'(flags()), 32'(5'b00001));
    chk("illegal steps", 32'(steps_done), 32'd2);
    n_steps = 4'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1 chk("err ignores start", 32'(flags()), 32'(5'b00001));
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    #1 chk("err abort idle", 32'(flags()), 32'(5'b00000));
    chk("err abort steps", 32'(steps_done), 32'd2);

    // Abort during RUN.
    @(negedge clk); mode = 1'b0; n_steps = 4'd6; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin @(negedge clk); start = 1'b0; end
    abort = 1'b1;
    #1 chk("abort cnt_en", 32'(cnt_en), 32'd0);
    chk("abort steps c3", 32'(steps_done), 32'd1);
    @(negedge clk); abort = 1'b0;
    #1 chk("abort idle", 32'(flags()), 32'(5'b00000));
    chk("abort steps kept", 32'(steps_done), 32'd1);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin @(negedge clk); #1 if (done) pulses++; end
    chk("abort no done", 32'(pulses), 32'd0);

    // Randomized runs against the outcome model.
    for (int i = 0; i < 25; i++) begin
      logic       rm;
      logic [3:0] rn;
      logic [2:0] rt;
      rm = 1'($urandom_range(0, 1));
      rn = 4'($urandom_range(0, 15));
      rt = 3'($urandom_range(0, 7));
      ref_model(rm, rn, rt, r_err, r_k, r_code);
      run_check(rm, rn, rt, r_err, r_k, r_code, $sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_counter_ctrl.md
# seq_counter_ctrl

Run controller for the 5-state T-flip-flop sequence counter (000→010→111→101→110→000). It clears the counter, gates its count enable, and runs it for a programmed number of steps or until a target code appears. It flags illegal counter codes and reports completion to the surrounding logic. It sits between the top-level control logic and an enable-gated instance of the sequence counter.

## Interface
- STEP_W, 4: width of step-count request and step counter.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch a run; sampled only in IDLE.
- abort  in  1  cancel current run or clear ERR; ignored in IDLE.
- mode  in  1  0 = run n_steps steps; 1 = run until counter code == target. Latched at start.
- n_steps  in  STEP_W  step count for mode 0. Latched at start.
- target  in  3  stop code {Q_A,Q_B,Q_C} for mode 1. Latched at start.
- q_a, q_b, q_c  in  1 each  current counter outputs.
- cnt_clr  out  1  counter clear to 000; registered from state.
- cnt_en  out  1  counter advances one step on the edge ending a cycle in which this is high; combinational.
- busy  out  1  high in CLEAR and RUN.
- done  out  1  one-cycle completion pulse.
- err  out  1  high while in ERR.
- steps_done  out  STEP_W  enable cycles issued in the last or current run; holds after DONE/ERR until next start.

## Operation
- States: IDLE, CLEAR, RUN, DONE, ERR. Reset → IDLE, with all outputs 0 and steps_done = 0.
- **IDLE:**
  - On start, latch mode/n_steps/target and zero steps_done.
  - If mode=1 and target ∈ {001,011,100} (unreachable), go to ERR.
  - Otherwise go to CLEAR.
- **CLEAR:** cnt_clr=1 for exactly one cycle; the counter holds 000 afterwards. Next state is RUN.
- **RUN, mode 0:**
  - If remaining==0: cnt_en=0 and go to DONE.
  - Else: cnt_en=1, remaining−1, steps_done+1.
- **RUN, mode 1:**
  - If q == target: cnt_en=0 and go to DONE.
  - Else: cnt_en=1, steps_done+1.
- **RUN, illegal code:** in either mode, if q ∈ {001,011,100} in any RUN cycle, cnt_en=0 and go to ERR. This check takes priority over the done checks.
- **DONE:** done=1 for one cycle, then IDLE.
- **ERR:** err=1. Stays in ERR until abort or rst, then IDLE. start is ignored in ERR.
- **abort** in CLEAR/RUN/DONE/ERR:
  - Forces cnt_en=0 in the same cycle.
  - Next state is IDLE.
  - No done pulse is issued.
  - steps_done keeps its value.
- **Priority:** rst > abort > state logic. start while busy is ignored.
- **Width rules:** steps_done wraps modulo 2^STEP_W. In mode 1, steps_done never exceeds 4.

## Timing
- Cycle 0 is the cycle in which start is sampled high in IDLE.
  - CLEAR occupies cycle 1.
  - RUN begins at cycle 2.
  - done is asserted in cycle k+3, where k = number of enable cycles issued.
- Mode 0: k = n_steps. The counter code at done is sequence index n_steps mod 5.
- Mode 1: k = index of target in the sequence (000→0, 010→1, 111→2, 101→3, 110→4).
- Unreachable target: err rises in cycle 1; no CLEAR, cnt_clr never asserted.
- busy falls in the same cycle that done rises.
- cnt_en depends combinationally only on state, the latched registers, q, and abort. There is no combinational path from start.

## Test plan
- Reset mid-RUN (mode 0, n_steps=7, rst in cycle 4):
  - Next cycle: IDLE, all outputs 0, steps_done=0.
  - No done pulse.
- Mode 0, n_steps=3:
  - cnt_clr in cycle 1.
  - cnt_en high in cycles 2–4.
  - done in cycle 6, counter=101, steps_done=3.
- Mode 0, n_steps=0: done in cycle 3, cnt_en never high, counter=000. A second run with n_steps=7 ends at code 111 (7 mod 5 = 2).
- Mode 1, target=110: 4 enable cycles, done in cycle 7, steps_done=4.
- Mode 1, target=000: done in cycle 3 with 0 steps. Mode 1, target=011: err in cycle 1, cnt_clr never asserted. abort then returns to IDLE next cycle.
- Mode 0, n_steps=5, counter model forced to 100 in cycle 4:
  - cnt_en=0 that cycle; err from cycle 5.
  - start ignored while in ERR.
  - abort mid-RUN in a separate run: cnt_en drops the same cycle, no done pulse.
